// File: rtl/run_ctrl_pkg.sv
// Shared command, state and stop-cause codes for the run/step controller.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package run_ctrl_pkg;

  typedef logic [1:0] cmd_t;
  typedef logic [1:0] state_t;
  typedef logic [1:0] cause_t;

  // Host command codes
  localparam cmd_t CMD_RUN   = 2'd0;
  localparam cmd_t CMD_STEP  = 2'd1;
  localparam cmd_t CMD_STOP  = 2'd2;
  localparam cmd_t CMD_CLEAR = 2'd3;

  // Controller state codes
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RUN     = 2'd1;
  localparam state_t ST_STEP    = 2'd2;
  localparam state_t ST_STOPPED = 2'd3;

  // Stop causes; host STOP and budget expiry share one code
  localparam cause_t CAUSE_NONE  = 2'd0;
  localparam cause_t CAUSE_HALT  = 2'd1;
  localparam cause_t CAUSE_BREAK = 2'd2;
  localparam cause_t CAUSE_LIMIT = 2'd3;

endpackage

// File: rtl/run_ctrl_if.sv
// Host command port of the run/step controller (valid/ready).
// Latency: a command is taken on the edge where CMD_VALID & CMD_READY.
// Backpressure: CMD_READY drops only while a single step is in flight.
interface run_ctrl_if;
  import run_ctrl_pkg::*;

  logic CMD_VALID;
  cmd_t CMD;
  logic CMD_READY;

  modport master (output CMD_VALID, output CMD, input CMD_READY);
  modport slave  (input CMD_VALID, input CMD, output CMD_READY);

endinterface

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Latency: q updates on the edge after clr/inc.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Clear wins over increment; increment stops at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run/step controller owning the CPU enable: run, single step, breakpoint, halt, budget.
// Latency: EN_L low the cycle after RUN/STEP accept; stop drops EN_L same cycle, STATE/CAUSE/DONE next edge.
// Backpressure: CMD_READY is low only in STEP; commands are otherwise always accepted.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  run_ctrl_if.slave        host,
  input  logic [7:0]       PC,
  input  logic             HALT_INS,
  input  logic             BP_EN,
  input  logic [7:0]       BP_ADDR,
  output logic             EN_L,
  output logic [1:0]       STATE,
  output logic [1:0]       CAUSE,
  output logic             DONE,
  output logic [CNT_W-1:0] ICOUNT
);

  // run_cnt only needs to reach MAX_CYCLES
  localparam int unsigned RUN_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;
  localparam logic [RUN_W-1:0] MAX_V = RUN_W'(MAX_CYCLES);

  state_t           state, state_nxt;
  cause_t           cause, cause_nxt;
  logic             done_nxt;
  logic             skip_bp, skip_set;
  logic [RUN_W-1:0] run_cnt;
  logic             cmd_rdy, accept, exec;
  logic             run_clr, ic_clr;
  logic             halt_c, bp_c, lim_c, stop_c;

  assign cmd_rdy        = (state != ST_STEP);
  assign host.CMD_READY = cmd_rdy;
  assign accept         = host.CMD_VALID & cmd_rdy;

  // Stop conditions evaluated against the instruction sitting at PC
  always_comb begin
    halt_c = HALT_INS;
    bp_c   = BP_EN && (PC == BP_ADDR) && !skip_bp;
    lim_c  = (MAX_CYCLES != 0) && (run_cnt == MAX_V);
    stop_c = (state == ST_RUN) && (halt_c || bp_c || lim_c);
  end

  // Enable is gated by reset so the CPU freezes the moment reset asserts
  always_comb begin
    EN_L = !(RESET && ((state == ST_STEP) || ((state == ST_RUN) && !stop_c)));
    exec = !EN_L;
  end

  // FSM next state, stop cause and DONE request
  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    done_nxt  = 1'b0;
    run_clr   = 1'b0;
    skip_set  = 1'b0;
    ic_clr    = accept && (host.CMD == CMD_CLEAR);
    if (ic_clr) cause_nxt = CAUSE_NONE;
    case (state)
      ST_IDLE, ST_STOPPED: begin
        if (accept && ((host.CMD == CMD_RUN) || (host.CMD == CMD_STEP))) begin
          if (HALT_INS) begin
            state_nxt = ST_STOPPED;
            cause_nxt = CAUSE_HALT;
            done_nxt  = 1'b1;
          end else if (host.CMD == CMD_RUN) begin
            state_nxt = ST_RUN;
            run_clr   = 1'b1;
            skip_set  = 1'b1;
          end else begin
            state_nxt = ST_STEP;
          end
        end
      end
      ST_RUN: begin
        if (stop_c) begin
          state_nxt = ST_STOPPED;
          done_nxt  = 1'b1;
          if (halt_c)    cause_nxt = CAUSE_HALT;
          else if (bp_c) cause_nxt = CAUSE_BREAK;
          else           cause_nxt = CAUSE_LIMIT;
        end else if (accept && (host.CMD == CMD_STOP)) begin
          // The instruction in this cycle still commits
          state_nxt = ST_STOPPED;
          cause_nxt = CAUSE_LIMIT;
          done_nxt  = 1'b1;
        end
      end
      ST_STEP: begin
        state_nxt = ST_STOPPED;
        cause_nxt = CAUSE_NONE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, cause, DONE pulse and breakpoint-skip registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      cause   <= CAUSE_NONE;
      DONE    <= 1'b0;
      skip_bp <= 1'b0;
    end else begin
      state <= state_nxt;
      cause <= cause_nxt;
      DONE  <= done_nxt;
      if (skip_set)  skip_bp <= 1'b1;
      else if (exec) skip_bp <= 1'b0;
    end
  end

  assign STATE = state;
  assign CAUSE = cause;

  sat_counter #(.W(CNT_W)) u_icount (
    .clk   (CLK),
    .rst_n (RESET),
    .clr   (ic_clr),
    .inc   (exec),
    .q     (ICOUNT)
  );

  sat_counter #(.W(RUN_W)) u_run_cnt (
    .clk   (CLK),
    .rst_n (RESET),
    .clr   (run_clr),
    .inc   (exec),
    .q     (run_cnt)
  );

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run/step controller for the single-cycle `cpu`. It owns the CPU's active-low enable `EN_L` and sequences free-running execution, single-stepping, breakpoints and a per-run cycle budget. It reports why execution stopped and counts executed instructions for the host/debug interface. It sits between the host command port and the `cpu` instance; `PC` and the decoded halt flag are fed back from the CPU.

## Interface
- `MAX_CYCLES`, default 0: per-run instruction budget. 0 disables the budget.
- `CNT_W`, default 16: width of the executed-instruction counter.
- `CLK  in  1`: clock, rising edge.
- `RESET  in  1`: asynchronous, active-low reset.
- `CMD_VALID  in  1`: host command valid.
- `CMD  in  2`: command code. `RUN`=0, `STEP`=1, `STOP`=2, `CLEAR`=3.
- `CMD_READY  out  1`: controller can accept a command.
- `PC  in  8`: current CPU program counter.
- `HALT_INS  in  1`: CPU decoder flags a halt instruction at `PC`.
- `BP_EN  in  1`: breakpoint enable.
- `BP_ADDR  in  8`: breakpoint address.
- `EN_L  out  1`: CPU enable, active-low. 0 means the CPU commits the instruction at `PC` this edge.
- `STATE  out  2`: `IDLE`=0, `RUN`=1, `STEP`=2, `STOPPED`=3.
- `CAUSE  out  2`: last stop cause. `NONE/STEP`=0, `HALT`=1, `BREAK`=2, `LIMIT_OR_STOP`=3. A separate `LIMIT` bit is not exposed; see Operation.
- `DONE  out  1`: one-cycle pulse when execution stops.
- `ICOUNT  out  CNT_W`: count of instructions executed, i.e. edges with `EN_L`=0.

## Operation
- **Handshake:** a command is accepted on the edge where `CMD_VALID & CMD_READY`. `CMD_READY`=0 only in `STEP`; it is 1 in every other state.
- **`EN_L` logic:** `EN_L` is combinational. `EN_L` = 0 iff `STATE`=`STEP`, or `STATE`=`RUN` and no stop condition is true this cycle. Otherwise `EN_L` = 1.
- **Stop conditions in `RUN`, checked in priority order:**
  - `HALT_INS`.
  - `BP_EN & PC==BP_ADDR & !skip_bp`.
  - `MAX_CYCLES`≠0 and `run_cnt==MAX_CYCLES`.
  - On a stop, the instruction at `PC` is not executed. The next state is `STOPPED`, `CAUSE` is set, and `DONE` pulses.
- **`skip_bp`:** set when `RUN` is entered, cleared after the first executed instruction. This lets a run resume from a breakpoint address.
- **`run_cnt`:** cleared on entry to `RUN`, increments on each executed instruction.
- **`IDLE`/`STOPPED` + `RUN`:**
  - If `HALT_INS`=1, stay in/enter `STOPPED`, set `CAUSE`=`HALT`, pulse `DONE`.
  - Otherwise go to `RUN`.
- **`IDLE`/`STOPPED` + `STEP`:**
  - If `HALT_INS`=1, behave as `RUN` does with `HALT_INS`=1.
  - Otherwise go to `STEP`. `STEP` lasts exactly one cycle (`EN_L`=0, breakpoint ignored), then `STOPPED` with `CAUSE`=`NONE/STEP` and `DONE`=1.
- **`RUN` + `STOP`:** the instruction in the accepting cycle executes. Then `STOPPED`, `CAUSE`=`LIMIT_OR_STOP`, `DONE`=1.
  - If a stop condition is also true in that cycle, the stop condition's cause wins.
- **`CLEAR` (any accepting state):** `ICOUNT`←0 and `CAUSE`←0. State is unchanged.
  - `CLEAR` in the same cycle as an executed instruction: the clear wins, so `ICOUNT`=0.
- **Ignored commands:** `RUN` or `STEP` while in `RUN` is accepted and has no effect. `STOP` in `IDLE`/`STOPPED` is accepted and has no effect; no `DONE`.
- **`ICOUNT`:** saturates at all-ones and never wraps.

## Timing
- **Reset values** (asynchronous, `RESET`=0): `STATE`=`IDLE`, `EN_L`=1, `CMD_READY`=1, `CAUSE`=0, `DONE`=0, `ICOUNT`=0, `run_cnt`=0, `skip_bp`=0.
- **Reset mid-run:** `EN_L` rises to 1 immediately and combinationally, without waiting for a clock.
- **Latency:**
  - Command accept → first `EN_L`=0: next cycle.
  - Stop decision → `EN_L`=1: same cycle, combinational.
  - Stop decision → `STATE`/`CAUSE`/`DONE` update: next edge.
- **`DONE`:** registered, high for exactly one cycle, in the cycle after the state transition edge.
- **Single step:** `PC` advances exactly once per `STEP`.

## Structure
- **Shared package `run_ctrl_pkg`:** command codes, state codes and cause codes. The `cpu` top-level and the test bench both import it.
- **One sub-module, `sat_counter`** (parameter `W`; inputs `clr`, `inc`; output `q`). Instantiated for `ICOUNT` and for `run_cnt`.
- **Top block contains:** the FSM, the stop-condition priority logic, and `skip_bp`.

## Test plan
- **Reset:** `RESET`=0 during RUN → `EN_L`=1 immediately. After release: `STATE`=`IDLE`, `ICOUNT`=0.
- **STEP ×3 from `PC`=0x00:** exactly 3 `DONE` pulses; `PC`=0x06 (+2 per instruction); `ICOUNT`=3; `CMD_READY`=0 only during each `STEP` cycle.
- **Breakpoint:** `BP_EN`=1, `BP_ADDR`=0x08, `RUN` from 0x00 → stops with `PC`=0x08, `CAUSE`=`BREAK`, `ICOUNT`=4. A second `RUN` → executes 0x08 and does not re-break immediately.
- **Halt:** `HALT_INS` asserted at `PC`=0x0C → `EN_L`=1 that cycle, `CAUSE`=`HALT`. `RUN` again → `DONE` with no instruction executed.
- **Budget:** `MAX_CYCLES`=5, `RUN` → exactly 5 instructions, `CAUSE`=`LIMIT_OR_STOP`. Then STOP on the same cycle that `PC` hits an enabled breakpoint → `CAUSE`=`BREAK`.
- **Counter:** saturation with `CNT_W`=4 → 16 steps leave `ICOUNT`=0xF. `CLEAR` coincident with an executed instruction → `ICOUNT`=0.
